// File: rtl/ember_alu.sv
// ember_alu: 64-bit integer ALU for the Ember execute stage.
// One operation is accepted per cycle when valid is high; result and flags
// are registered (latency 1) and hold while valid is low.
// Optional feature macro: EMBER_ALU_MUL_EN enables the 64x64 multiply (op 0A);
// without it op 0A is treated as an unknown operation.
module ember_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    typedef enum logic [7:0] {
        OP_ADD  = 8'h00,
        OP_SUB  = 8'h01,
        OP_AND  = 8'h02,
        OP_OR   = 8'h03,
        OP_XOR  = 8'h04,
        OP_NOT  = 8'h05,
        OP_SHL  = 8'h06,
        OP_SHR  = 8'h07,
        OP_SAR  = 8'h08,
        OP_CMP  = 8'h09,
        OP_MUL  = 8'h0A,
        OP_INC  = 8'h0B,
        OP_DEC  = 8'h0C,
        OP_PASS = 8'h0D
    } opCode_e;

    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;

    logic [WIDTH-1:0] w_addB;
    logic [WIDTH:0]   w_sum;
    logic             w_addOvf;
    logic [WIDTH-1:0] w_subB;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_subOvf;
    logic [5:0]       w_shamt;
    logic [5:0]       w_shlIdx;
    logic [5:0]       w_shrIdx;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_sar;
    logic             w_shlOut;
    logic             w_shrOut;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_carry;
    logic             w_ovf;

    // Shared adder and subtractor; INC/DEC reuse them with a constant 1 operand
    always_comb begin
        w_addB   = (op == OP_INC) ? WIDTH'(1) : b;
        w_sum    = {1'b0, a} + {1'b0, w_addB};
        w_addOvf = (a[WIDTH-1] == w_addB[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        w_subB   = (op == OP_DEC) ? WIDTH'(1) : b;
        w_diff   = a - w_subB;
        w_borrow = a < w_subB;
        w_subOvf = (a[WIDTH-1] != w_subB[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    end

    // Barrel shifts on the low six bits of b, plus the last bit shifted out
    // (left shift loses bit 64-n, which is -n modulo 64; right shifts lose bit n-1)
    always_comb begin
        w_shamt  = b[5:0];
        w_shlIdx = 6'd0 - w_shamt;
        w_shrIdx = w_shamt - 6'd1;
        w_shl    = a << w_shamt;
        w_shr    = a >> w_shamt;
        w_sar    = $signed(a) >>> w_shamt;
        w_shlOut = (w_shamt != 6'd0) && a[w_shlIdx];
        w_shrOut = (w_shamt != 6'd0) && a[w_shrIdx];
    end

`ifdef EMBER_ALU_MUL_EN
    logic [2*WIDTH-1:0] w_prod;

    // Full-width unsigned product; only the low half is returned, the high half flags loss
    always_comb begin
        w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end
`endif

    // Result and flag selection for the presented opcode
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_zero  = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = w_addOvf;
            end
            OP_SUB, OP_DEC: begin
                w_res   = w_diff;
                w_carry = w_borrow;
                w_ovf   = w_subOvf;
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOT:  w_res = ~a;
            OP_SHL: begin
                w_res   = w_shl;
                w_carry = w_shlOut;
            end
            OP_SHR: begin
                w_res   = w_shr;
                w_carry = w_shrOut;
            end
            OP_SAR: begin
                w_res   = w_sar;
                w_carry = w_shrOut;
            end
            OP_CMP: begin
                w_res   = r_res;
                w_carry = w_borrow;
                w_ovf   = w_subOvf;
            end
`ifdef EMBER_ALU_MUL_EN
            OP_MUL: begin
                w_res   = w_prod[WIDTH-1:0];
                w_carry = |w_prod[2*WIDTH-1:WIDTH];
                w_ovf   = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            OP_PASS: w_res = b;
            default: w_res = '0;
        endcase
        if (op == OP_CMP) begin
            w_zero = (a == b);
        end else begin
            w_zero = (w_res == '0);
        end
    end

    // Output registers: reset wins over valid, idle cycles hold everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
        end else if (valid) begin
            r_res   <= w_res;
            r_zero  <= w_zero;
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_eq    <= (a == b);
            r_lt    <= ($signed(a) < $signed(b));
            r_gt    <= ($signed(a) > $signed(b));
        end
    end

    assign res      = r_res;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign eq       = r_eq;
    assign lt       = r_lt;
    assign gt       = r_gt;

endmodule

// File: tb/tb_ember_alu.sv
// tb_ember_alu: directed vector table followed by randomized traffic compared
// against an arithmetic reference model of the ALU.
module tb_ember_alu;

    localparam logic [7:0] ADD = 8'h00, SUB = 8'h01, AND_ = 8'h02, OR_ = 8'h03;
    localparam logic [7:0] XOR_ = 8'h04, NOT_ = 8'h05, SHL = 8'h06, SHR = 8'h07;
    localparam logic [7:0] SAR = 8'h08, CMP = 8'h09, MUL = 8'h0A, INC = 8'h0B;
    localparam logic [7:0] DEC = 8'h0C, PASS = 8'h0D;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINS = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXS = 64'h7FFF_FFFF_FFFF_FFFF;
`ifdef EMBER_ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        carry;
        logic        ovf;
        logic        eq;
        logic        lt;
        logic        gt;
    } outs_t;

    typedef struct {
        string       name;
        logic        rstN;
        logic        vld;
        logic [7:0]  opc;
        logic [63:0] opA;
        logic [63:0] opB;
        outs_t       exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        eq;
    logic        lt;
    logic        gt;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    ember_alu dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .res      (res),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow),
        .eq       (eq),
        .lt       (lt),
        .gt       (gt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t mkOut(logic [63:0] r, logic z, logic c, logic o,
                                    logic e, logic l, logic g);
        outs_t t;
        t.res = r; t.zero = z; t.carry = c; t.ovf = o; t.eq = e; t.lt = l; t.gt = g;
        return t;
    endfunction

    function automatic vec_t mkVec(string n, logic rn, logic v, logic [7:0] o,
                                   logic [63:0] va, logic [63:0] vb, outs_t e);
        vec_t t;
        t.name = n; t.rstN = rn; t.vld = v; t.opc = o; t.opA = va; t.opB = vb; t.exp = e;
        return t;
    endfunction

    // True when a 66-bit signed value does not fit in 64 signed bits
    function automatic logic notRepresentable(logic signed [65:0] s);
        return !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
    endfunction

    // Reference model: plain wide arithmetic over the operation rules
    function automatic outs_t refModel(logic [7:0] o, logic [63:0] va, logic [63:0] vb,
                                       outs_t prev);
        outs_t t;
        logic [127:0] u;
        logic signed [127:0] us;
        logic signed [65:0] s;
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        int sh;
        logic unknown;
        t = mkOut(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        unknown = 1'b0;
        sh = int'(vb % 64);
        sa = $signed({{2{va[63]}}, va});
        sb = $signed({{2{vb[63]}}, vb});
        case (o)
            ADD, INC: begin
                if (o == INC) sb = 66'sd1;
                u = 128'(va) + 128'(sb[63:0]);
                t.res = u[63:0]; t.carry = u[64];
                s = sa + sb; t.ovf = notRepresentable(s);
            end
            SUB, DEC, CMP: begin
                if (o == DEC) sb = 66'sd1;
                t.res = va - sb[63:0];
                t.carry = va < sb[63:0];
                s = sa - sb; t.ovf = notRepresentable(s);
            end
            AND_: t.res = va & vb;
            OR_:  t.res = va | vb;
            XOR_: t.res = va ^ vb;
            NOT_: t.res = ~va;
            SHL: begin
                u = {64'd0, va} << sh;
                t.res = u[63:0]; t.carry = u[64];
            end
            SHR: begin
                u = {va, 64'd0} >> sh;
                t.res = u[127:64]; t.carry = u[63];
            end
            SAR: begin
                us = $signed({va, 64'd0}) >>> sh;
                t.res = us[127:64]; t.carry = us[63];
            end
            MUL: begin
                if (MulEn) begin
                    u = 128'(va) * 128'(vb);
                    t.res = u[63:0]; t.carry = |u[127:64]; t.ovf = t.carry;
                end else begin
                    unknown = 1'b1;
                end
            end
            PASS: t.res = vb;
            default: unknown = 1'b1;
        endcase
        if (unknown) begin
            t.res = 64'd0; t.carry = 1'b0; t.ovf = 1'b0;
        end
        if (o == CMP) begin
            t.res = prev.res;
            t.zero = (va == vb);
        end else begin
            t.zero = (t.res == 64'd0);
        end
        t.eq = (va == vb);
        t.lt = ($signed(va) < $signed(vb));
        t.gt = ($signed(va) > $signed(vb));
        return t;
    endfunction

    // Drive one cycle of inputs at the falling edge, then step past the rising edge
    task automatic applyStimulus(logic rn, logic v, logic [7:0] o, logic [63:0] va,
                                 logic [63:0] vb);
        @(negedge clk);
        rst = rn; valid = v; op = o; a = va; b = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(string name, string field, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s got %h expected %h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(string name, outs_t e);
        checkField(name, "res", res, e.res);
        checkField(name, "zero", 64'(zero), 64'(e.zero));
        checkField(name, "carry", 64'(carry), 64'(e.carry));
        checkField(name, "overflow", 64'(overflow), 64'(e.ovf));
        checkField(name, "eq", 64'(eq), 64'(e.eq));
        checkField(name, "lt", 64'(lt), 64'(e.lt));
        checkField(name, "gt", 64'(gt), 64'(e.gt));
    endtask

    // Directed table, then randomized traffic against the reference model
    initial begin
        outs_t zeroOut;
        outs_t mState;
        logic rn;
        logic v;
        logic [7:0] o;
        logic [63:0] va;
        logic [63:0] vb;
        rst = 1'b0; valid = 1'b0; op = 8'h00; a = 64'd0; b = 64'd0;
        zeroOut = mkOut(64'd0, 0, 0, 0, 0, 0, 0);

        vecs.push_back(mkVec("reset1", 0, 1, ADD, 64'd5, 64'd5, zeroOut));
        vecs.push_back(mkVec("reset2", 0, 0, ADD, 64'd0, 64'd0, zeroOut));
        vecs.push_back(mkVec("idleAfterReset", 1, 0, ADD, 64'd3, 64'd4, zeroOut));
        vecs.push_back(mkVec("addWrap", 1, 1, ADD, ONES, 64'd1, mkOut(64'd0, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mkVec("addOvf", 1, 1, ADD, MAXS, 64'd1, mkOut(MINS, 0, 0, 1, 0, 0, 1)));
        vecs.push_back(mkVec("subBorrow", 1, 1, SUB, 64'd3, 64'd5,
                             mkOut(64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, 1, 0)));
        vecs.push_back(mkVec("cmpEqual", 1, 1, CMP, 64'd5, 64'd5,
                             mkOut(64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 1, 0, 0)));
        vecs.push_back(mkVec("shlCarry", 1, 1, SHL, 64'h8000_0000_0000_0001, 64'd1,
                             mkOut(64'd2, 0, 1, 0, 0, 1, 0)));
        vecs.push_back(mkVec("sar63", 1, 1, SAR, MINS, 64'd63, mkOut(ONES, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkVec("shrZero", 1, 1, SHR, 64'h1234, 64'd0, mkOut(64'h1234, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mkVec("and", 1, 1, AND_, 64'hF0F0, 64'hFF00, mkOut(64'hF000, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkVec("orBackToBack", 1, 1, OR_, 64'hF0F0, 64'hFF00, mkOut(64'hFFF0, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkVec("holdOr", 1, 0, XOR_, 64'd9, 64'd1, mkOut(64'hFFF0, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkVec("mul", 1, 1, MUL, 64'h1_0000_0000, 64'h1_0000_0000,
                             mkOut(64'd0, 1, MulEn, MulEn, 1, 0, 0)));
        vecs.push_back(mkVec("unknownOp", 1, 1, 8'h20, 64'd1, 64'd2, mkOut(64'd0, 1, 0, 0, 0, 1, 0)));
        vecs.push_back(mkVec("incWrap", 1, 1, INC, ONES, 64'd0, mkOut(64'd0, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mkVec("decOvf", 1, 1, DEC, MINS, 64'd0, mkOut(MAXS, 0, 0, 1, 0, 1, 0)));
        vecs.push_back(mkVec("decBorrow", 1, 1, DEC, 64'd0, 64'd0, mkOut(ONES, 0, 1, 0, 1, 0, 0)));
        vecs.push_back(mkVec("not", 1, 1, NOT_, 64'd0, 64'd0, mkOut(ONES, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(mkVec("pass", 1, 1, PASS, 64'd0, 64'h55, mkOut(64'h55, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkVec("resetMidStream", 0, 1, ADD, 64'd1, 64'd1, zeroOut));
        vecs.push_back(mkVec("xorZero", 1, 1, XOR_, 64'hAA, 64'hAA, mkOut(64'd0, 1, 0, 0, 1, 0, 0)));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].vld, vecs[i].opc, vecs[i].opA, vecs[i].opB);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Hand sequence: reset, then three back-to-back ops and a hold
        applyStimulus(0, 0, ADD, 64'd0, 64'd0);
        checkOutput("seqReset", zeroOut);
        applyStimulus(1, 1, SUB, 64'd10, 64'd4);
        checkOutput("seqSub", mkOut(64'd6, 0, 0, 0, 0, 0, 1));
        applyStimulus(1, 1, CMP, 64'd1, 64'd2);
        checkOutput("seqCmpHoldsRes", mkOut(64'd6, 0, 1, 0, 0, 1, 0));
        applyStimulus(1, 1, SHR, 64'h8, 64'h1C3);
        checkOutput("seqShrMod64", mkOut(64'h1, 0, 0, 0, 0, 1, 0));
        applyStimulus(1, 0, PASS, 64'd7, 64'd7);
        checkOutput("seqHold", mkOut(64'h1, 0, 0, 0, 0, 1, 0));

        // Randomized traffic: model state follows reset/valid rules directly
        mState = mkOut(64'h1, 0, 0, 0, 0, 1, 0);
        for (int n = 0; n < 600; n++) begin
            rn = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 9) < 8);
            o  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: va = 64'd0;
                1: va = ONES;
                2: va = MINS;
                default: va = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: vb = va;
                1: vb = 64'd1;
                2: vb = 64'($urandom_range(0, 200));
                default: vb = {$urandom, $urandom};
            endcase
            if (!rn) begin
                mState = zeroOut;
            end else if (v) begin
                mState = refModel(o, va, vb, mState);
            end
            applyStimulus(rn, v, o, va, vb);
            checkOutput($sformatf("rand%0d_op%h", n, o), mState);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
